// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one mon_prod at a time.
// Optional build macro RSA_EXP_SKIP_LEAD_EN: skip squares of Montgomery 1 before the first set bit.
module rsa_exp_ctrl #(
    parameter int EBITS      = 256,
    parameter int LOG_EBITS  = 8,
    parameter int LOG_BITLEN = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [EBITS-1:0]      exponent,
    input  logic [LOG_EBITS:0]    exp_len,
    input  logic [LOG_BITLEN:0]   mp_count_cfg,
    output logic                  mp_start,
    output logic [1:0]            mp_op_code,
    output logic [LOG_BITLEN:0]   mp_count,
    input  logic                  mp_stop,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           op_cnt
);

    typedef enum logic [2:0] {IDLE, NEXT, ISSUE, ARM, WAIT, DONE} state_t;

    localparam logic [1:0] OPXX = 2'd0;
    localparam logic [1:0] OPXM = 2'd1;
    localparam logic [1:0] OPX1 = 2'd2;
    localparam logic [LOG_EBITS:0] EBITS_W = (LOG_EBITS+1)'(EBITS);

    state_t                state_q;
    logic [EBITS-1:0]      e_q;
    logic [LOG_EBITS:0]    rem_q;
    logic                  mul_pend_q;
    logic                  fin_q;
`ifdef RSA_EXP_SKIP_LEAD_EN
    logic                  seen_q;
`endif
    logic                  mp_start_q;
    logic [1:0]            op_q;
    logic [LOG_BITLEN:0]   mp_count_q;
    logic                  busy_q;
    logic                  done_q;
    logic [15:0]           op_cnt_q;

    logic [LOG_EBITS:0]    len_clamp;
    logic [LOG_EBITS:0]    rem_m1;
    logic                  cur_bit;

    assign len_clamp = (exp_len > EBITS_W) ? EBITS_W : exp_len;
    assign rem_m1    = rem_q - 1'b1;
    assign cur_bit   = e_q[rem_m1[LOG_EBITS-1:0]];

    assign mp_start   = mp_start_q;
    assign mp_op_code = op_q;
    assign mp_count   = mp_count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign op_cnt     = op_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            e_q        <= '0;
            rem_q      <= '0;
            mul_pend_q <= 1'b0;
            fin_q      <= 1'b0;
`ifdef RSA_EXP_SKIP_LEAD_EN
            seen_q     <= 1'b0;
`endif
            mp_start_q <= 1'b0;
            op_q       <= OPXX;
            mp_count_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            op_cnt_q   <= '0;
        end else begin
            mp_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: if (go) begin
                    e_q        <= exponent;
                    rem_q      <= len_clamp;
                    mp_count_q <= mp_count_cfg;
                    mul_pend_q <= 1'b0;
                    fin_q      <= 1'b0;
`ifdef RSA_EXP_SKIP_LEAD_EN
                    seen_q     <= 1'b0;
`endif
                    op_cnt_q   <= '0;
                    busy_q     <= 1'b1;
                    state_q    <= NEXT;
                end
                NEXT: begin
                    if (mul_pend_q) begin
                        op_q       <= OPXM;
                        mul_pend_q <= 1'b0;
                        mp_start_q <= 1'b1;
                        state_q    <= ISSUE;
                    end else if (rem_q != '0) begin
                        rem_q <= rem_m1;
`ifdef RSA_EXP_SKIP_LEAD_EN
                        // Leading zeros square Montgomery 1: consume silently.
                        if (!seen_q) begin
                            if (cur_bit) begin
                                op_q       <= OPXM;
                                seen_q     <= 1'b1;
                                mp_start_q <= 1'b1;
                                state_q    <= ISSUE;
                            end
                        end else begin
                            op_q       <= OPXX;
                            mul_pend_q <= cur_bit;
                            mp_start_q <= 1'b1;
                            state_q    <= ISSUE;
                        end
`else
                        op_q       <= OPXX;
                        mul_pend_q <= cur_bit;
                        mp_start_q <= 1'b1;
                        state_q    <= ISSUE;
`endif
                    end else if (!fin_q) begin
                        op_q       <= OPX1;
                        fin_q      <= 1'b1;
                        mp_start_q <= 1'b1;
                        state_q    <= ISSUE;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                ISSUE: begin
                    if (op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
                    state_q <= ARM;
                end
                // mp_stop is still high from the previous op here.
                ARM:  state_q <= WAIT;
                WAIT: if (mp_stop) state_q <= NEXT;
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Randomized bench for rsa_exp_ctrl with a behavioural mon_prod and an op-sequence reference model.
module tb_rsa_exp_ctrl;

`ifdef RSA_EXP_SKIP_LEAD_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go  = 1'b0;
    logic [255:0] exponent = '0;
    logic [8:0]   exp_len = '0;
    logic [8:0]   mp_count_cfg = '0;
    logic         mp_start;
    logic [1:0]   mp_op_code;
    logic [8:0]   mp_count;
    logic         mp_stop;
    logic         busy;
    logic         done;
    logic [15:0]  op_cnt;

    rsa_exp_ctrl dut (
        .clk(clk), .rst(rst), .go(go), .exponent(exponent), .exp_len(exp_len),
        .mp_count_cfg(mp_count_cfg), .mp_start(mp_start), .mp_op_code(mp_op_code),
        .mp_count(mp_count), .mp_stop(mp_stop), .busy(busy), .done(done), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mon_prod model: stop stays high one cycle past start, then low for a random latency.
    int   lat_max = 2;
    logic arm_m;
    int   cnt_m;
    always @(posedge clk) begin
        if (rst) begin
            mp_stop <= 1'b1;
            arm_m   <= 1'b0;
            cnt_m   <= 0;
        end else if (mp_start) begin
            arm_m <= 1'b1;
        end else if (arm_m) begin
            arm_m   <= 1'b0;
            mp_stop <= 1'b0;
            cnt_m   <= $urandom_range(lat_max, 0);
        end else if (!mp_stop) begin
            if (cnt_m == 0) mp_stop <= 1'b1;
            else cnt_m <= cnt_m - 1;
        end
    end

    // Protocol monitor.
    int         cyc = 0;
    int         viol = 0;
    int         ndone = 0;
    int         done_cyc = 0;
    int         rise_cyc = 0;
    int         first_cyc = 0;
    bit         first_pending = 1'b0;
    bit         inflight = 1'b0;
    logic       prev_start = 1'b0;
    logic       prev_stop = 1'b1;
    logic [1:0] cur_op = 2'd0;
    logic [1:0] opq[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) inflight = 1'b0;
        if (mp_start) begin
            if (prev_start) viol++;
            if (arm_m || !mp_stop) viol++;
            if (first_pending) begin
                first_pending = 1'b0;
                first_cyc = cyc;
            end else if (cyc - rise_cyc != 2) viol++;
            opq.push_back(mp_op_code);
            cur_op = mp_op_code;
            inflight = 1'b1;
        end else if (inflight) begin
            if (mp_op_code != cur_op) viol++;
        end
        if (mp_stop && !prev_stop) begin
            rise_cyc = cyc;
            inflight = 1'b0;
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
        prev_start = mp_start;
        prev_stop  = mp_stop;
    end

    // Reference: expected op list from square-and-multiply rules.
    logic [1:0] expq[$];
    int         lead;
    function automatic void build(input logic [255:0] e, input int len);
        int n;
        bit seen;
        n = (len > 256) ? 256 : len;
        seen = 1'b0;
        lead = 0;
        expq.delete();
        for (int i = n - 1; i >= 0; i--) begin
            if (SKIP && !seen) begin
                if (e[i]) begin expq.push_back(2'd1); seen = 1'b1; end
                else lead++;
            end else begin
                expq.push_back(2'd0);
                if (e[i]) expq.push_back(2'd1);
            end
        end
        expq.push_back(2'd2);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int k0;

    task automatic start(input logic [255:0] e, input int len, input int lmax, input bit hold_go);
        build(e, len);
        lat_max = lmax;
        opq.delete();
        ndone = 0;
        viol = 0;
        first_pending = 1'b1;
        tick();
        exponent = e;
        exp_len = 9'(len);
        mp_count_cfg = 9'($urandom);
        go = 1'b1;
        k0 = cyc;
        tick();
        chk("busy_after_go", busy, 1);
        if (hold_go) begin
            exponent = ~e;
            tick();
            tick();
        end
        go = 1'b0;
    endtask

    task automatic run(input logic [255:0] e, input int len, input int lmax, input bit hold_go);
        logic [8:0] cfg;
        int bad;
        start(e, len, lmax, hold_go);
        cfg = mp_count_cfg;
        for (int i = 0; i < 20000 && ndone == 0; i++) tick();
        chk("done_seen", ndone, 1);
        chk("mp_count", mp_count, cfg);
        tick();
        chk("busy_end", busy, 0);
        tick();
        chk("done_once", ndone, 1);
        chk("op_cnt", op_cnt, expq.size());
        chk("first_start", first_cyc - k0, 2 + lead);
        chk("done_lat", done_cyc - rise_cyc, 2);
        chk("protocol", viol, 0);
        bad = -1;
        for (int i = 0; i < expq.size() || i < opq.size(); i++) begin
            if (i >= expq.size() || i >= opq.size() || opq[i] != expq[i]) begin
                bad = i;
                break;
            end
        end
        chk("opseq_first_bad", bad, -1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_start", mp_start, 0);
        chk("rst_op", mp_op_code, 0);
        chk("rst_count", mp_count, 0);
        chk("rst_opcnt", op_cnt, 0);
        rst = 1'b0;

        run(256'hB, 4, 3, 1'b0);
        chk("plan_1011_cnt", op_cnt, SKIP ? 7 : 8);
        run(256'h0, 0, 2, 1'b0);
        chk("plan_len0_cnt", op_cnt, 1);
        run({256{1'b1}}, 300, 0, 1'b0);
        chk("plan_len300_cnt", op_cnt, SKIP ? 512 : 513);

        // Reset in WAIT of the third op.
        start(256'hB, 4, 4, 1'b0);
        for (int i = 0; i < 500 && !(opq.size() == 3 && !mp_stop && !arm_m); i++) tick();
        chk("rst_reached_op3", opq.size(), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_opcnt", op_cnt, 0);
        chk("mid_rst_start", mp_start, 0);
        chk("mid_rst_op", mp_op_code, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("mid_rst_no_done", ndone, 0);
        chk("mid_rst_idle", busy, 0);
        run(256'hB, 4, 2, 1'b1);

        for (int r = 0; r < 10; r++) begin
            logic [255:0] e;
            e = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (r % 3 == 0) e = e >> $urandom_range(255, 200);
            run(e, (r == 9) ? 256 : int'($urandom_range(40, 0)), int'($urandom_range(4, 0)),
                1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
